// File: rtl/dmem_ctrl.sv
// Y86 data-memory sequencer: decodes memory-stage ops and arbitrates a single-port RAM
// between the CPU (priority) and a loader. Optional macro: DMEM_ADDR_CHECK_EN.
module dmem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic [3:0]        i_icode,
  input  logic [63:0]       i_valA,
  input  logic [63:0]       i_valE,
  input  logic [63:0]       i_valP,
  output logic [63:0]       o_valM,
  output logic              o_cpu_done,
  output logic              o_mem_stall,
  output logic              o_dmem_error,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [63:0]       i_ld_wdata,
  output logic [63:0]       o_ld_rdata,
  output logic              o_ld_gnt,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [63:0]       o_ram_wdata,
  input  logic [63:0]       i_ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              r_state;
  logic                r_owner_cpu;
  logic                r_rd;
  logic [3:0]          r_cnt;
  logic [63:0]         r_valM;
  logic [63:0]         r_ld_rdata;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [63:0]         r_ram_wdata;
  logic                r_cpu_done;
  logic                r_ld_gnt;
  logic                r_dmem_error;

  logic                w_cpu_wr;
  logic                w_cpu_rd;
  logic                w_cpu_access;
  logic [63:0]         w_cpu_addr_op;
  logic [63:0]         w_cpu_wdata;
  logic                w_addr_bad;
  logic                w_finish;

  always_comb begin
    w_cpu_wr      = 1'b0;
    w_cpu_rd      = 1'b0;
    w_cpu_addr_op = i_valE;
    w_cpu_wdata   = i_valA;
    case (i_icode)
      4'h4, 4'hA: w_cpu_wr = 1'b1;
      4'h8: begin
        w_cpu_wr    = 1'b1;
        w_cpu_wdata = i_valP;
      end
      4'h5: w_cpu_rd = 1'b1;
      4'h9, 4'hB: begin
        w_cpu_rd      = 1'b1;
        w_cpu_addr_op = i_valA;
      end
      default: ;
    endcase
  end

  assign w_cpu_access = w_cpu_wr | w_cpu_rd;

`ifdef DMEM_ADDR_CHECK_EN
  // Only CPU accesses are range-checked; the loader address is already ADDR_W wide.
  assign w_addr_bad = w_cpu_access & (|w_cpu_addr_op[63:ADDR_W]);
`else
  assign w_addr_bad = 1'b0;
`endif

  // Last cycle of the RAM access: read data is valid and the done pulse is launched.
  assign w_finish = ((r_state == S_ISSUE) && (WAIT_CYCLES == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_owner_cpu  <= 1'b0;
      r_rd         <= 1'b0;
      r_cnt        <= 4'd0;
      r_valM       <= 64'd0;
      r_ld_rdata   <= 64'd0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= 64'd0;
      r_cpu_done   <= 1'b0;
      r_ld_gnt     <= 1'b0;
      r_dmem_error <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      r_ld_gnt   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cpu_req) begin
            r_owner_cpu <= 1'b1;
            if (!w_cpu_access || w_addr_bad) begin
              r_state    <= S_DONE;
              r_cpu_done <= 1'b1;
              if (w_addr_bad) r_dmem_error <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_ram_en   <= 1'b1;
              r_ram_we   <= w_cpu_wr;
              r_ram_addr <= w_cpu_addr_op[ADDR_W-1:0];
              r_rd       <= w_cpu_rd;
              if (w_cpu_wr) r_ram_wdata <= w_cpu_wdata;
            end
          end else if (i_ld_req) begin
            r_owner_cpu <= 1'b0;
            r_state     <= S_ISSUE;
            r_ram_en    <= 1'b1;
            r_ram_we    <= i_ld_we;
            r_ram_addr  <= i_ld_addr;
            r_rd        <= ~i_ld_we;
            if (i_ld_we) r_ram_wdata <= i_ld_wdata;
          end
        end
        S_ISSUE: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          if (WAIT_CYCLES != 0) begin
            r_state <= S_WAIT;
            r_cnt   <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt > 4'd1) r_cnt <= r_cnt - 4'd1;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_finish) begin
        r_state <= S_DONE;
        r_cnt   <= 4'd0;
        if (r_owner_cpu) r_cpu_done <= 1'b1;
        else             r_ld_gnt   <= 1'b1;
        if (r_rd) begin
          if (r_owner_cpu) r_valM     <= i_ram_rdata;
          else             r_ld_rdata <= i_ram_rdata;
        end
      end
    end
  end

  assign o_valM       = r_valM;
  assign o_ld_rdata   = r_ld_rdata;
  assign o_cpu_done   = r_cpu_done;
  assign o_ld_gnt     = r_ld_gnt;
  assign o_dmem_error = r_dmem_error;
  assign o_ram_en     = r_ram_en;
  assign o_ram_we     = r_ram_we;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_wdata  = r_ram_wdata;
  assign o_mem_stall  = i_cpu_req & ~r_cpu_done;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table for CPU ops, hand sequences for
// arbitration and mid-access reset; completions are checked through scoreboard queues.
module tb_dmem_ctrl;

  localparam int AW = 10;
`ifdef DMEM_ADDR_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic [3:0]    icode = 4'h0;
  logic [63:0]   valA = 64'd0, valE = 64'd0, valP = 64'd0;
  logic [63:0]   valM;
  logic          cpu_done, mem_stall, dmem_error;
  logic          ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [63:0]   ld_wdata = 64'd0;
  logic [63:0]   ld_rdata;
  logic          ld_gnt;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata;

  dmem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cpu_req(cpu_req), .i_icode(icode),
    .i_valA(valA), .i_valE(valE), .i_valP(valP), .o_valM(valM),
    .o_cpu_done(cpu_done), .o_mem_stall(mem_stall), .o_dmem_error(dmem_error),
    .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
    .o_ld_rdata(ld_rdata), .o_ld_gnt(ld_gnt), .o_ram_en(ram_en), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency (WAIT_CYCLES = 1).
  logic [63:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]    icode;
    logic [63:0]   a, e, p;
    logic          en, we;
    logic [AW-1:0] addr;
    logic [63:0]   wd;
    int            lat;
    logic [63:0]   data;
    logic          err;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    int          cyc;
    logic        err;
    int          id;
  } sb_t;

  vec_t vecs [14];
  sb_t  sb_cpu [$];
  sb_t  sb_ld  [$];
  sb_t  mon_e;

  function automatic vec_t mk(input logic [3:0] ic, input logic [63:0] a, e, p,
                              input logic en, we, input logic [AW-1:0] addr,
                              input logic [63:0] wd, input int lat,
                              input logic [63:0] data, input logic err);
    vec_t v;
    v.icode = ic; v.a = a; v.e = e; v.p = p; v.en = en; v.we = we;
    v.addr = addr; v.wd = wd; v.lat = lat; v.data = data; v.err = err;
    return v;
  endfunction

  // Scoreboard consumer: every completion pulse pops the matching owner's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_done) begin
        check("ld_gnt_with_cpu_done", {63'd0, ld_gnt}, 64'd0);
        if (sb_cpu.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cpu_done_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          mon_e = sb_cpu.pop_front();
          $display("cpu op %0d done at cycle %0d valM=%h err=%0b", mon_e.id, cyc, valM, dmem_error);
          check($sformatf("cpu%0d_valM", mon_e.id), valM, mon_e.data);
          check($sformatf("cpu%0d_done_cycle", mon_e.id), 64'(cyc), 64'(mon_e.cyc));
          check($sformatf("cpu%0d_err", mon_e.id), {63'd0, dmem_error}, {63'd0, mon_e.err});
        end
      end
      if (ld_gnt) begin
        if (sb_ld.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ld_gnt_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          mon_e = sb_ld.pop_front();
          $display("ld op %0d granted at cycle %0d ld_rdata=%h", mon_e.id, cyc, ld_rdata);
          check($sformatf("ld%0d_rdata", mon_e.id), ld_rdata, mon_e.data);
          check($sformatf("ld%0d_gnt_cycle", mon_e.id), 64'(cyc), 64'(mon_e.cyc));
          check($sformatf("ld%0d_err", mon_e.id), {63'd0, dmem_error}, {63'd0, mon_e.err});
        end
      end
    end
  end

  task automatic cpu_vec(input int i);
    vec_t v;
    int t0, n_en, en_cyc;
    bit done;
    logic en_we;
    logic [AW-1:0] en_addr;
    logic [63:0] en_wd;
    v = vecs[i]; n_en = 0; en_cyc = -1; done = 0;
    en_we = 1'b0; en_addr = '0; en_wd = 64'd0;
    @(posedge clk); #1;
    icode = v.icode; valA = v.a; valE = v.e; valP = v.p; cpu_req = 1'b1;
    t0 = cyc;
    sb_cpu.push_back('{v.data, t0 + v.lat, v.err, i});
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (cyc == t0) check($sformatf("vec%0d_stall_c0", i), {63'd0, mem_stall}, 64'd1);
      if (ram_en) begin
        n_en++; en_cyc = cyc; en_we = ram_we; en_addr = ram_addr; en_wd = ram_wdata;
      end
      if (cpu_done) begin
        done = 1;
        check($sformatf("vec%0d_stall_done", i), {63'd0, mem_stall}, 64'd0);
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL vec%0d_timeout: got no cpu_done expected one within 20 cycles", i);
    end
    check($sformatf("vec%0d_ram_en_count", i), 64'(n_en), {63'd0, v.en});
    if (v.en) begin
      check($sformatf("vec%0d_issue_cycle", i), 64'(en_cyc), 64'(t0 + 1));
      check($sformatf("vec%0d_ram_we", i), {63'd0, en_we}, {63'd0, v.we});
      check($sformatf("vec%0d_ram_addr", i), 64'(en_addr), 64'(v.addr));
      if (v.we) check($sformatf("vec%0d_ram_wdata", i), en_wd, v.wd);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic ld_op(input int id, input logic we, input logic [AW-1:0] addr,
                       input logic [63:0] wd, input logic [63:0] exp_data,
                       input int lat, input logic exp_err);
    int t0;
    bit done;
    done = 0;
    @(posedge clk); #1;
    ld_we = we; ld_addr = addr; ld_wdata = wd; ld_req = 1'b1;
    t0 = cyc;
    sb_ld.push_back('{exp_data, t0 + lat, exp_err, id});
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (cyc == t0 + lat - 2) begin
        check($sformatf("ld%0d_ram_en_we", id), {62'd0, ram_en, ram_we}, {62'd0, 1'b1, we});
        check($sformatf("ld%0d_ram_addr", id), 64'(ram_addr), 64'(addr));
        if (we) check($sformatf("ld%0d_ram_wdata", id), ram_wdata, wd);
      end
      if (ld_gnt) done = 1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL ld%0d_timeout: got no ld_gnt expected one within 20 cycles", id);
    end
    @(posedge clk); #1;
    ld_req = 1'b0;
  endtask

  initial begin
    int t0;
    bit seen;
    vecs[0]  = mk(4'h4, 64'hAB, 64'd5, 64'd0, 1, 1, 10'd5, 64'hAB, 3, 64'd0, 0);
    vecs[1]  = mk(4'h5, 64'd0, 64'd5, 64'd0, 1, 0, 10'd5, 64'd0, 3, 64'hAB, 0);
    vecs[2]  = mk(4'h9, 64'd5, 64'd3, 64'd0, 1, 0, 10'd5, 64'd0, 3, 64'hAB, 0);
    vecs[3]  = mk(4'h8, 64'h99, 64'd7, 64'h40, 1, 1, 10'd7, 64'h40, 3, 64'hAB, 0);
    vecs[4]  = mk(4'hB, 64'd7, 64'd2, 64'd0, 1, 0, 10'd7, 64'd0, 3, 64'h40, 0);
    vecs[5]  = mk(4'h6, 64'd1, 64'd1, 64'd0, 0, 0, 10'd0, 64'd0, 1, 64'h40, 0);
    vecs[6]  = mk(4'hA, 64'h1234_5678_9ABC_DEF0, 64'd9, 64'd0, 1, 1, 10'd9,
                  64'h1234_5678_9ABC_DEF0, 3, 64'h40, 0);
    vecs[7]  = mk(4'h5, 64'd0, 64'd9, 64'd0, 1, 0, 10'd9, 64'd0, 3, 64'h1234_5678_9ABC_DEF0, 0);
    vecs[8]  = mk(4'h0, 64'd0, 64'd0, 64'd0, 0, 0, 10'd0, 64'd0, 1, 64'h1234_5678_9ABC_DEF0, 0);
    vecs[9]  = mk(4'h4, 64'h55, 64'd0, 64'd0, 1, 1, 10'd0, 64'h55, 3, 64'h1234_5678_9ABC_DEF0, 0);
`ifdef DMEM_ADDR_CHECK_EN
    vecs[10] = mk(4'h5, 64'd0, 64'h400, 64'd0, 0, 0, 10'd0, 64'd0, 1, 64'h1234_5678_9ABC_DEF0, 1);
`else
    vecs[10] = mk(4'h5, 64'd0, 64'h400, 64'd0, 1, 0, 10'd0, 64'd0, 3, 64'h55, 0);
`endif
    vecs[11] = mk(4'h5, 64'd0, 64'd7, 64'd0, 1, 0, 10'd7, 64'd0, 3, 64'h40, ERR_ON);
    vecs[12] = mk(4'h5, 64'd0, 64'd20, 64'd0, 1, 0, 10'd20, 64'd0, 3, 64'hDEAD_BEEF, ERR_ON);
    vecs[13] = mk(4'h5, 64'd0, 64'd9, 64'd0, 1, 0, 10'd9, 64'd0, 3, 64'h1234_5678_9ABC_DEF0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valM", valM, 64'd0);
    check("rst_ld_rdata", ld_rdata, 64'd0);
    check("rst_pulses", {62'd0, cpu_done, ld_gnt}, 64'd0);
    check("rst_ram_en_we", {62'd0, ram_en, ram_we}, 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_wdata", ram_wdata, 64'd0);
    check("rst_err_stall", {62'd0, dmem_error, mem_stall}, 64'd0);
    $display("reset state checked at cycle %0d", cyc);
    rst_n = 1'b1;

    for (int i = 0; i <= 11; i++) cpu_vec(i);

    ld_op(0, 1'b1, 10'd20, 64'hDEAD_BEEF, 64'd0, 3, ERR_ON);

    // Simultaneous requests: CPU first, loader granted 3+W cycles after cpu_done.
    fork
      cpu_vec(12);
      ld_op(1, 1'b0, 10'd7, 64'd0, 64'h40, 7, ERR_ON);
    join

    // Reset during the WAIT cycle of a read aborts the op and clears outputs.
    @(posedge clk); #1;
    icode = 4'h5; valE = 64'd9; cpu_req = 1'b1;
    t0 = cyc;
    repeat (3) @(negedge clk);
    check("mid_rst_in_wait_cycle", 64'(cyc), 64'(t0 + 2));
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("mid_rst_valM", valM, 64'd0);
    check("mid_rst_ld_rdata", ld_rdata, 64'd0);
    check("mid_rst_err_done", {62'd0, dmem_error, cpu_done}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_done || ram_en) seen = 1;
    end
    check("mid_rst_no_activity", {63'd0, seen}, 64'd0);
    $display("mid-access reset sequence finished at cycle %0d", cyc);

    cpu_vec(13);

    repeat (2) @(negedge clk);
    check("sb_cpu_drained", 64'(sb_cpu.size()), 64'd0);
    check("sb_ld_drained", 64'(sb_ld.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencing controller and two-requester arbiter for the Y86 data memory. It sits between the SEQ memory stage and a single-port synchronous data RAM. It decodes the memory-stage `icode` into a read, a write or no access, and drives the RAM port with a configurable wait-state count. It also shares the RAM with a program/data loader port, which has lower priority. The memory stage is held off with `mem_stall` until `cpu_done` pulses.

## Interface
- `ADDR_W`, 10: RAM word-address width (1024 words).
- `WAIT_CYCLES`, 1: cycles between `ram_en` and valid `ram_rdata`. Legal range is 0..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cpu_req`  in  1  memory-stage request; held high until `cpu_done`.
- `icode`  in  4  instruction code of the requesting instruction.
- `valA`, `valE`, `valP`  in  64 each  operands from execute/decode.
- `valM`  out  64  read result; registered.
- `cpu_done`  out  1  one-cycle completion pulse for the CPU op.
- `mem_stall`  out  1  `cpu_req & ~cpu_done`; combinational.
- `dmem_error`  out  1  sticky address error (see Configuration).
- `ld_req`  in  1  loader request; held until `ld_gnt`.
- `ld_we`  in  1  loader write enable.
- `ld_addr`  in  `ADDR_W`  loader word address.
- `ld_wdata`  in  64  loader write data.
- `ld_rdata`  out  64  loader read result; registered.
- `ld_gnt`  out  1  one-cycle completion pulse for the loader op.
- `ram_en`, `ram_we`  out  1 each  RAM strobe and write enable.
- `ram_addr`  out  `ADDR_W`  RAM word address.
- `ram_wdata`  out  64  RAM write data.
- `ram_rdata`  in  64  RAM read data.

## Operation
- Addresses are word indices. The RAM address is the operand's low `ADDR_W` bits.
- Decode, captured in IDLE when a request is accepted:
  - `rmmovq` (4) and `pushq` (A): write `valA` at address `valE`.
  - `call` (8): write `valP` at address `valE`.
  - `mrmovq` (5): read at address `valE`.
  - `ret` (9) and `popq` (B): read at address `valA`.
  - Any other `icode`: no access.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE transitions:
  - If `cpu_req` is high, owner becomes CPU. Go to DONE for a no-access op, otherwise go to ISSUE.
  - Else if `ld_req` is high, owner becomes loader and go to ISSUE.
  - CPU has fixed priority. A loader request is serviced only when the CPU is not requesting.
- ISSUE: `ram_en` is high for exactly this one cycle, with `ram_we`/`ram_addr`/`ram_wdata` from the latched op. Next state is WAIT if `WAIT_CYCLES>0`, else DONE.
- WAIT:
  - A down-counter is loaded with `WAIT_CYCLES` on entry and decrements each cycle.
  - On the final cycle, read data is captured from `ram_rdata` (reads only) into `valM` or `ld_rdata` according to owner.
  - Next state is DONE.
- DONE: pulse `cpu_done` or `ld_gnt` according to owner, then go to IDLE. Requests are not sampled in DONE.
- Requesters drop their request in the cycle after their done/grant pulse. A request still high at the next IDLE is treated as a new access.
- `valM` and `ld_rdata` hold their last value across writes and no-access ops.
- Outside ISSUE, `ram_en`=0 and `ram_we`=0. `ram_addr`/`ram_wdata` hold their last value.

## Timing
- Reset values: state IDLE; `valM`=0; `ld_rdata`=0; `ram_en`/`ram_we`=0; `ram_addr`=0; `ram_wdata`=0; `cpu_done`/`ld_gnt`=0; `dmem_error`=0; wait counter 0.
- Count cycle 0 as the cycle in which the request is sampled high in IDLE.
- Read or write: ISSUE in cycle 1, WAIT in cycles 2..1+W, DONE (pulse) in cycle 2+W. Read data is valid in the DONE cycle.
- With `WAIT_CYCLES`=0, DONE occurs in cycle 2.
- No-access op: DONE in cycle 1.
- Back-to-back: the minimum spacing between accepted requests is 3+W cycles.
- Simultaneous `cpu_req` and `ld_req` in IDLE: CPU wins. The loader is accepted at the next IDLE if the CPU is idle.
- Reset mid-operation returns immediately to IDLE and aborts any pending pulse.
  - A write whose ISSUE edge has already occurred is committed in RAM.
  - Otherwise the write is not committed.

## Configuration
- Macro: `DMEM_ADDR_CHECK_EN`.
- Defined:
  - A CPU access whose address operand has any bit in [63:`ADDR_W`] set performs no RAM access.
  - The FSM goes directly to DONE in cycle 1 and `dmem_error` sets with the `cpu_done` pulse.
  - `dmem_error` stays high until reset.
  - Loader accesses are never checked.
- Undefined: upper address bits are truncated silently and `dmem_error` is tied 0.

## Test plan
- Reset with `WAIT_CYCLES`=1: all outputs 0. `icode`=4, `valE`=5, `valA`=0xAB, `cpu_req` → `ram_we` pulses in cycle 1 with `ram_addr`=5; `cpu_done` in cycle 3.
- `icode`=5, `valE`=5 after the above write → `valM`=0xAB in cycle 3. Then `icode`=9 with `valA`=5 → `valM`=0xAB.
- `icode`=8, `valE`=7, `valP`=0x40, then `icode`=B with `valA`=7 → `valM`=0x40. `icode`=6 → `cpu_done` in cycle 1 with no `ram_en`.
- `cpu_req` and `ld_req` raised together → CPU completes first. `ld_gnt` follows 3+W cycles later, and `ld_rdata` returns the loader-addressed word.
- With macro defined: `icode`=5, `valE`=0x400 → no `ram_en`, `cpu_done` and `dmem_error`=1 in cycle 1, and `dmem_error` stays 1 until `rst_n` is asserted. Without the macro: access to word 0, `dmem_error`=0.
- Assert `rst_n`=0 during WAIT of a read → next cycle is IDLE, no `cpu_done`, `valM`=0.
